ipf_lcu_feeder: RTL

//  Upstream stage of the image-processing filter. Reads a 128x128 8-bit image

---
 rtl/ipf_pkg.sv | 57 +++++
 rtl/ipf_lcu_feeder_if.sv | 40 ++++
 rtl/ipf_skid_fifo2.sv | 51 +++++
 rtl/ipf_lcu_feeder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipf_pkg.sv
// ipf_pkg: shared definitions for the image-processing filter front end.
// LCU size encodings, parameter-word field layout, image geometry, feeder FSM states.
package ipf_pkg;

    localparam int unsigned IMG_W  = 128;
    localparam int unsigned IMG_AW = 14;
    localparam int unsigned PRM_W  = 24;
    localparam int unsigned PRM_AW = 6;

    // Parameter word field positions
    localparam int unsigned PRM_TYPE_LO = 22;
    localparam int unsigned PRM_BAND_LO = 17;
    localparam int unsigned PRM_WO_BIT  = 16;
    localparam int unsigned PRM_OFF_LO  = 0;

    typedef enum logic [1:0] {
        LCU_16 = 2'd0,
        LCU_32 = 2'd1,
        LCU_64 = 2'd2
    } lcu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRM0,
        ST_STREAM,
        ST_FLUSH,
        ST_DONE
    } feed_state_e;

    typedef struct packed {
        logic [1:0]  ty;
        logic [4:0]  band_pos;
        logic        wo_class;
        logic [15:0] offset;
    } prm_t;

    function automatic prm_t prm_unpack(input logic [PRM_W-1:0] w);
        prm_t p;
        p.ty       = w[PRM_TYPE_LO +: 2];
        p.band_pos = w[PRM_BAND_LO +: 5];
        p.wo_class = w[PRM_WO_BIT];
        p.offset   = w[PRM_OFF_LO +: 16];
        return p;
    endfunction

    // Encoding 3 is reserved and behaves as the largest LCU size
    function automatic lcu_size_e size_norm(input logic [1:0] cfg);
        lcu_size_e s;
        case (cfg)
            2'd0:    s = LCU_16;
            2'd1:    s = LCU_32;
            default: s = LCU_64;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ipf_lcu_feeder_if.sv
// ipf_lcu_feeder_if: control, image RAM, parameter RAM and pixel-stream signals of the feeder.
interface ipf_lcu_feeder_if;
    import ipf_pkg::*;

    logic                start;
    logic [1:0]          cfg_lcu_size;
    logic                img_rd;
    logic [IMG_AW-1:0]   img_addr;
    logic [7:0]          img_data;
    logic                prm_rd;
    logic [PRM_AW-1:0]   prm_addr;
    logic [PRM_W-1:0]    prm_data;
    logic                stall;
    logic                in_en;
    logic [7:0]          din;
    logic [1:0]          ipf_type;
    logic [4:0]          ipf_band_pos;
    logic                ipf_wo_class;
    logic [15:0]         ipf_offset;
    logic [2:0]          lcu_x;
    logic [2:0]          lcu_y;
    logic [1:0]          lcu_size;
    logic                done;
    logic                prm_err;

    modport master (
        input  start, cfg_lcu_size, img_data, prm_data, stall,
        output img_rd, img_addr, prm_rd, prm_addr, in_en, din,
               ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
               lcu_x, lcu_y, lcu_size, done, prm_err
    );

    modport slave (
        output start, cfg_lcu_size, img_data, prm_data, stall,
        input  img_rd, img_addr, prm_rd, prm_addr, in_en, din,
               ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
               lcu_x, lcu_y, lcu_size, done, prm_err
    );

endinterface

// File: rtl/ipf_skid_fifo2.sv
// ipf_skid_fifo2: 2-entry 8-bit FIFO absorbing RAM read returns while downstream stalls.
module ipf_skid_fifo2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic [1:0] count
);

    logic [7:0] mem_q [2];
    logic [7:0] mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;

    // Pointer/occupancy update; caller guarantees no push when full, no pop when empty
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // Storage and pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = cnt_q;

endmodule

// File: rtl/ipf_lcu_feeder.sv
// ipf_lcu_feeder: reads a 128x128 image and per-LCU parameters, streams pixels LCU by LCU.
// Optional feature macro IPF_FEED_TYPE_CLAMP_EN: ipf_type 3 is output as 0 and sets sticky prm_err.
module ipf_lcu_feeder
    import ipf_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    ipf_lcu_feeder_if.master bus
);

    feed_state_e       state_q, state_d;
    lcu_size_e         size_q, size_d;
    logic              prm_pend_q, prm_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic [5:0]        col_q, col_d, row_q, row_d;
    logic [2:0]        ix_q, ix_d, iy_q, iy_d;
    logic [2:0]        lx_q, lx_d, ly_q, ly_d;
    logic [11:0]       pix_q, pix_d;
    logic [PRM_W-1:0]  pf_q, pf_d;
    logic              pf_vld_q, pf_vld_d;
    prm_t              prm_q, prm_d;
    logic              in_en_q, in_en_d;
    logic [7:0]        din_q, din_d;
`ifdef IPF_FEED_TYPE_CLAMP_EN
    logic              prm_err_q, prm_err_d;
`endif

    logic [5:0]        sz_m1;
    logic [2:0]        n_m1;
    logic [11:0]       pix_last;
    logic [PRM_AW-1:0] cur_idx;
    logic [IMG_AW-1:0] addr_raw;
    logic              img_rd;
    logic [IMG_AW-1:0] img_addr;
    logic              prm_rd;
    logic [PRM_AW-1:0] prm_addr;
    logic              load_prm;
    logic [PRM_W-1:0]  load_word;
    logic              pop;
    logic [1:0]        fifo_cnt;
    logic [7:0]        fifo_head;
    logic [2:0]        occ;
    logic              out_last_lcu;

    function automatic prm_t prm_decode(input logic [PRM_W-1:0] w);
        prm_t p;
        p = prm_unpack(w);
`ifdef IPF_FEED_TYPE_CLAMP_EN
        if (p.ty == 2'd3) p.ty = 2'd0;
`endif
        return p;
    endfunction

    ipf_skid_fifo2 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_pend_q),
        .push_data (bus.img_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_cnt)
    );

    // Size-dependent limits, image address packing and current LCU table index
    always_comb begin
        sz_m1    = 6'd63;
        n_m1     = 3'd1;
        pix_last = 12'd4095;
        cur_idx  = {4'b0, ly_q[0], lx_q[0]};
        addr_raw = {iy_q[0], row_q, ix_q[0], col_q};
        case (size_q)
            LCU_16: begin
                sz_m1    = 6'd15;
                n_m1     = 3'd7;
                pix_last = 12'd255;
                cur_idx  = {ly_q, lx_q};
                addr_raw = {iy_q, row_q[3:0], ix_q, col_q[3:0]};
            end
            LCU_32: begin
                sz_m1    = 6'd31;
                n_m1     = 3'd3;
                pix_last = 12'd1023;
                cur_idx  = {2'b0, ly_q[1:0], lx_q[1:0]};
                addr_raw = {iy_q[1:0], row_q[4:0], ix_q[1:0], col_q[4:0]};
            end
            default: ;
        endcase
    end

    // FSM next state, read issue, parameter prefetch and output-side LCU tracking
    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        prm_pend_d = prm_pend_q;
        col_d      = col_q;
        row_d      = row_q;
        ix_d       = ix_q;
        iy_d       = iy_q;
        lx_d       = lx_q;
        ly_d       = ly_q;
        pix_d      = pix_q;
        pf_d       = pf_q;
        pf_vld_d   = pf_vld_q;
        img_rd     = 1'b0;
        prm_rd     = 1'b0;
        prm_addr   = '0;
        load_prm   = 1'b0;
        load_word  = '0;
`ifdef IPF_FEED_TYPE_CLAMP_EN
        prm_err_d  = prm_err_q;
`endif

        pop          = (fifo_cnt != 2'd0) && !bus.stall;
        out_last_lcu = (lx_q == n_m1) && (ly_q == n_m1);
        // Credit a same-cycle pop so steady state sustains one read per cycle
        occ = {1'b0, fifo_cnt} + {2'b0, rd_pend_q} - {2'b0, pop};

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_PRM0;
                    size_d     = size_norm(bus.cfg_lcu_size);
                    prm_pend_d = 1'b0;
                    pf_vld_d   = 1'b0;
                    col_d      = '0;
                    row_d      = '0;
                    ix_d       = '0;
                    iy_d       = '0;
`ifdef IPF_FEED_TYPE_CLAMP_EN
                    prm_err_d  = 1'b0;
`endif
                end
            end
            ST_PRM0: begin
                if (!prm_pend_q) begin
                    prm_rd     = 1'b1;
                    prm_pend_d = 1'b1;
                end else begin
                    prm_pend_d = 1'b0;
                    load_prm   = 1'b1;
                    load_word  = bus.prm_data;
                    lx_d       = '0;
                    ly_d       = '0;
                    pix_d      = '0;
                    state_d    = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (occ < 3'd2) begin
                    img_rd = 1'b1;
                    if (col_q == sz_m1) begin
                        col_d = '0;
                        if (row_q == sz_m1) begin
                            row_d = '0;
                            if (ix_q == n_m1) begin
                                ix_d = '0;
                                if (iy_q == n_m1) begin
                                    iy_d    = '0;
                                    state_d = ST_FLUSH;
                                end else begin
                                    iy_d = iy_q + 3'd1;
                                end
                            end else begin
                                ix_d = ix_q + 3'd1;
                            end
                        end else begin
                            row_d = row_q + 6'd1;
                        end
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end
            end
            ST_FLUSH: begin
                if ((fifo_cnt == 2'd0) && !rd_pend_q) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Output side lags issue by at most a few pixels, so the prefetch
        // for LCU k+1 always lands long before the last pixel of LCU k pops.
        if ((state_q == ST_STREAM) || (state_q == ST_FLUSH)) begin
            if (prm_pend_q) begin
                pf_d       = bus.prm_data;
                pf_vld_d   = 1'b1;
                prm_pend_d = 1'b0;
            end else if (!pf_vld_q && !out_last_lcu) begin
                prm_rd     = 1'b1;
                prm_addr   = cur_idx + 6'd1;
                prm_pend_d = 1'b1;
            end
            if (pop) begin
                if (pix_q == pix_last) begin
                    pix_d = '0;
                    if (!out_last_lcu) begin
                        load_prm  = 1'b1;
                        load_word = pf_q;
                        pf_vld_d  = 1'b0;
                        if (lx_q == n_m1) begin
                            lx_d = '0;
                            ly_d = ly_q + 3'd1;
                        end else begin
                            lx_d = lx_q + 3'd1;
                        end
                    end
                end else begin
                    pix_d = pix_q + 12'd1;
                end
            end
        end

        prm_d = load_prm ? prm_decode(load_word) : prm_q;
`ifdef IPF_FEED_TYPE_CLAMP_EN
        if (load_prm && (load_word[PRM_TYPE_LO +: 2] == 2'd3)) prm_err_d = 1'b1;
`endif

        rd_pend_d = img_rd;
        in_en_d   = pop;
        din_d     = pop ? fifo_head : din_q;
        img_addr  = img_rd ? addr_raw : '0;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            size_q     <= LCU_16;
            prm_pend_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            ix_q       <= '0;
            iy_q       <= '0;
            lx_q       <= '0;
            ly_q       <= '0;
            pix_q      <= '0;
            pf_q       <= '0;
            pf_vld_q   <= 1'b0;
            prm_q      <= '0;
            in_en_q    <= 1'b0;
            din_q      <= '0;
`ifdef IPF_FEED_TYPE_CLAMP_EN
            prm_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            prm_pend_q <= prm_pend_d;
            rd_pend_q  <= rd_pend_d;
            col_q      <= col_d;
            row_q      <= row_d;
            ix_q       <= ix_d;
            iy_q       <= iy_d;
            lx_q       <= lx_d;
            ly_q       <= ly_d;
            pix_q      <= pix_d;
            pf_q       <= pf_d;
            pf_vld_q   <= pf_vld_d;
            prm_q      <= prm_d;
            in_en_q    <= in_en_d;
            din_q      <= din_d;
`ifdef IPF_FEED_TYPE_CLAMP_EN
            prm_err_q  <= prm_err_d;
`endif
        end
    end

    assign bus.img_rd       = img_rd;
    assign bus.img_addr     = img_addr;
    assign bus.prm_rd       = prm_rd;
    assign bus.prm_addr     = prm_addr;
    assign bus.in_en        = in_en_q;
    assign bus.din          = din_q;
    assign bus.ipf_type     = prm_q.ty;
    assign bus.ipf_band_pos = prm_q.band_pos;
    assign bus.ipf_wo_class = prm_q.wo_class;
    assign bus.ipf_offset   = prm_q.offset;
    assign bus.lcu_x        = lx_q;
    assign bus.lcu_y        = ly_q;
    assign bus.lcu_size     = size_q;
    assign bus.done         = (state_q == ST_DONE);
`ifdef IPF_FEED_TYPE_CLAMP_EN
    assign bus.prm_err      = prm_err_q;
`else
    assign bus.prm_err      = 1'b0;
`endif

endmodule
